output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Wormhole output-port allocator for the NoC router. One instance sits behind each of the router's output ports. It takes the per-input one-hot port requests produced by the `input_router` blocks and grants the output to exactly one input at a time. The grant is round-robin and is held from head flit to tail flit, so packets are never interleaved on a link.

## Interface
- `N_IN`, 5: number of requesting input ports.
- `TIMEOUT`, 256: watchdog limit in cycles. Used only when `OPA_WATCHDOG_EN` is defined.
- `clk` input 1: clock, rising edge.
- `arst` input 1: reset, asynchronous, active-low.
- `req_i` input `N_IN`: bit i is high when input i holds a valid flit routed to this output (that input's `router_port_o` bit ANDed with its valid).
- `flit_type_i` input `2*N_IN`: flit type of input i's current flit, in bits [2i+1:2i].
  - 00 = head, 01 = body, 10 = tail, 11 = head_tail.
- `fire_i` input 1: the output link accepted a flit this cycle (output valid & ready).
- `grant_o` output `N_IN`: one-hot owner of the output, or all-zero. Registered.
- `locked_o` output 1: the output is owned by an in-flight packet. Registered.
- `timeout_o` output 1: one-cycle pulse when the watchdog force-releases the lock. Registered.

## Operation
- Two states:
  - IDLE: `grant_o`=0, `locked_o`=0.
  - LOCKED: `grant_o` is one-hot, `locked_o`=1.
- Round-robin pointer `ptr` (width clog2(`N_IN`)) holds the index of the last winner. Search order is `ptr`+1, `ptr`+2, … modulo `N_IN`, wrapping past `N_IN`-1 to 0.
- IDLE, `req_i`≠0:
  - Winner w = first set bit of `req_i` in search order.
  - Next state LOCKED, `grant_o`←1<<w, `ptr`←w.
- IDLE, `req_i`=0: stay IDLE. `fire_i` is ignored in IDLE.
- LOCKED, release condition: `fire_i`=1 and the granted input's type is tail or head_tail.
  - Re-arbitrate in the same cycle over `req_i` with the releasing input's bit masked.
  - If any other input requests: switch `grant_o` to that winner, update `ptr`, stay LOCKED.
  - Otherwise: go to IDLE, `grant_o`←0.
  - The releasing input can win again only from a later cycle.
- LOCKED, `fire_i`=1 with type head or body: grant held.
- LOCKED, `fire_i`=0: grant held.
- Deassertion of the granted input's `req_i` while LOCKED is a wormhole stall. The grant is held regardless.
- Flit type is not checked for protocol errors. A head flit observed while LOCKED is treated as body.
- `grant_o` is never multi-hot. `locked_o` equals |`grant_o` at all times.

## Timing
- Reset (`arst`=0, asynchronous): `grant_o`=0, `locked_o`=0, `timeout_o`=0, `ptr`=`N_IN`-1 (input 0 has highest first priority), watchdog counter=0, state IDLE.
- Reset release is synchronised externally. The first arbitration happens on the first rising edge with `arst`=1.
- Latency from `req_i` rising (IDLE) to `grant_o` is 1 cycle. The first flit can fire in the cycle `grant_o` is visible.
- Release: on the edge after the tail `fire_i`, `grant_o` shows either the next winner (no bubble) or zero.
- Single-flit packet (head_tail): granted 1 cycle after request, released on its `fire_i` edge.
- Reset asserted mid-packet: lock dropped immediately. The upstream flow control must discard the partial packet.

## Configuration
- `OPA_WATCHDOG_EN` defined:
  - Counter `wd_cnt` (width clog2(`TIMEOUT`+1)) increments each LOCKED cycle with `fire_i`=0.
  - Cleared on any `fire_i`, on every grant change, and in IDLE.
  - When `wd_cnt` reaches `TIMEOUT`-1 while still stalled, the next edge force-releases exactly like a tail (same masked re-arbitration) and pulses `timeout_o`=1 for one cycle.
- `OPA_WATCHDOG_EN` not defined: no counter is generated, `timeout_o` is tied to 0, and a lock is released only by a tail/head_tail fire.

## Test plan
- Reset: hold `arst`=0 with `req_i`=5'b11111 → `grant_o`=0, `locked_o`=0. Release → `grant_o`=5'b00001 one cycle later.
- Round-robin: `req_i`=5'b10110 held, each input sends a 3-flit packet (head, body, tail, each fired) → grants in order 00010, 00100, 10000, 00010, with no idle cycle between packets.
- Wormhole hold: grant input 2, input 4 requests throughout, input 2 stalls 10 cycles (`fire_i`=0) between body flits → `grant_o` stays 00100 until input 2's tail fires, then becomes 10000 on the next edge.
- Single requester: only input 3 sends back-to-back head_tail packets → grant 01000, then IDLE for one cycle after each release (self-masked), then re-grant.
- Wrap-around: `ptr`=4, `req_i`=5'b10001 → input 0 wins. After its release, input 4 wins.
- Watchdog (`OPA_WATCHDOG_EN`, `TIMEOUT`=8): lock input 1, no `fire_i` for 8 cycles, input 2 requesting → `timeout_o` pulses once, `grant_o`=00100. Without the macro → grant is held indefinitely and `timeout_o` stays 0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// ============================================================================
// Module   : output_port_arbiter
// Brief    : Wormhole round-robin output-port allocator; grant held head..tail.
//            Optional stall watchdog enabled by defining OPA_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module output_port_arbiter #(
  parameter int N_IN    = 5,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [N_IN-1:0]     req_i,
  input  logic [2*N_IN-1:0]   flit_type_i,
  input  logic                fire_i,
  output logic [N_IN-1:0]     grant_o,
  output logic                locked_o,
  output logic                timeout_o
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]      r_state, w_state_nxt;
  logic [N_IN-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [1:0]      w_gtype;
  logic            w_release;
  logic            w_force;
  logic [N_IN-1:0] w_arb_req;
  logic            w_found;
  logic [PW-1:0]   w_win;

  always_comb begin
    w_gtype = 2'b00;
    for (int i = 0; i < N_IN; i++) begin
      if (r_grant[i]) w_gtype = w_gtype | flit_type_i[2*i +: 2];
    end
  end

  assign w_release = (r_state == S_LOCKED) &&
                     ((fire_i && (w_gtype == 2'b10 || w_gtype == 2'b11)) || w_force);

  // The releasing owner is masked so it can only win again from a later cycle.
  assign w_arb_req = (r_state == S_LOCKED) ? (req_i & ~r_grant) : req_i;

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    idx     = 0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!w_found && w_arb_req[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

`ifdef OPA_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wd, w_wd_nxt;
  logic          r_timeout;

  assign w_force  = (r_state == S_LOCKED) && !fire_i && (r_wd == WW'(TIMEOUT - 1));
  assign w_wd_nxt = (r_state == S_LOCKED && !fire_i && !w_force) ? r_wd + WW'(1) : '0;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= w_wd_nxt;
      r_timeout <= w_force;
    end
  end

  assign timeout_o = r_timeout;
`else
  // TIMEOUT has no effect without the watchdog; this term is constant false.
  assign w_force   = (TIMEOUT < 0);
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(N_IN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOCKED;
          w_grant_nxt = N_IN'(1) << w_win;
          w_ptr_nxt   = w_win;
        end
      end
      S_LOCKED: begin
        if (w_release) begin
          if (w_found) begin
            w_grant_nxt = N_IN'(1) << w_win;
            w_ptr_nxt   = w_win;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    grant_o  = r_grant;
    locked_o = (r_state == S_LOCKED);
  end

endmodule

`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
// ============================================================================
// Module   : tb_output_port_arbiter
// Brief    : Self-checking bench for output_port_arbiter (vectors + model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_output_port_arbiter;

  localparam int N  = 5;
  localparam int TB_TIMEOUT = 12;
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic         clk;
  logic         arst;
  logic [N-1:0] req_i;
  logic [2*N-1:0] flit_type_i;
  logic         fire_i;
  logic [N-1:0] grant_o;
  logic         locked_o;
  logic         timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: owner index (-1 = none), last winner, stall count
  int m_owner;
  int m_ptr;
  int m_wd;
  bit m_to;

  output_port_arbiter #(.N_IN(N), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_i       (req_i),
    .flit_type_i (flit_type_i),
    .fire_i      (fire_i),
    .grant_o     (grant_o),
    .locked_o    (locked_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   ft;
    logic         fire;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_wd    = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] rq, input logic [2*N-1:0] ft, input logic fr);
    logic [1:0] t;
    bit rel;
    bit frc;
    int w;
    rel  = 1'b0;
    frc  = 1'b0;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = pick(rq, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
      end
      m_wd = 0;
    end else begin
      t   = ft[2*m_owner +: 2];
      rel = fr && (t == TAIL || t == HT);
`ifdef OPA_WATCHDOG_EN
      frc = !fr && (m_wd == TB_TIMEOUT - 1);
`endif
      if (rel || frc) begin
        w = pick(rq & ~(N'(1) << m_owner), m_ptr);
        m_owner = w;
        if (w >= 0) m_ptr = w;
        m_wd = 0;
        m_to = frc;
      end else begin
        m_wd = fr ? 0 : m_wd + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] eg, input logic el, input logic et);
    n_cmp++;
    if (grant_o !== eg || locked_o !== el || timeout_o !== et) begin
      n_bad++;
      $display("FAIL %s: got grant=%b locked=%b timeout=%b, expected grant=%b locked=%b timeout=%b",
               nm, grant_o, locked_o, timeout_o, eg, el, et);
    end
  endtask

  task automatic drive_raw(input logic [N-1:0] rq, input logic [2*N-1:0] ft, input logic fr);
    req_i       = rq;
    flit_type_i = ft;
    fire_i      = fr;
    model_step(rq, ft, fr);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [1:0] t, input logic fr);
    drive_raw(rq, {N{t}}, fr);
  endtask

  task automatic do_reset(input string nm);
    arst = 1'b0;
    #1;
    chk(nm, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_i  = '0;
    fire_i = 1'b0;
    arst   = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{5'b10110, HEAD, 1'b0, 5'b00010};
    tbl[1] = '{5'b10110, HEAD, 1'b1, 5'b00010};
    tbl[2] = '{5'b10110, BODY, 1'b1, 5'b00010};
    tbl[3] = '{5'b10110, TAIL, 1'b1, 5'b00100};
    tbl[4] = '{5'b10110, HEAD, 1'b1, 5'b00100};
    tbl[5] = '{5'b10110, BODY, 1'b1, 5'b00100};
    tbl[6] = '{5'b10110, TAIL, 1'b1, 5'b10000};
    tbl[7] = '{5'b10110, HEAD, 1'b1, 5'b10000};
    tbl[8] = '{5'b10110, BODY, 1'b1, 5'b10000};
    tbl[9] = '{5'b10110, TAIL, 1'b1, 5'b00010};

    arst        = 1'b0;
    req_i       = 5'b11111;
    flit_type_i = '0;
    fire_i      = 1'b0;
    model_reset();

    // reset held with all inputs requesting
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_hold", '0, 1'b0, 1'b0);
    arst = 1'b1;
    drive(5'b11111, HEAD, 1'b0);
    chk("reset_first_grant", 5'b00001, 1'b1, 1'b0);

    // round-robin over three 3-flit packets, no bubbles
    do_reset("reset_before_rr");
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].req, tbl[i].ft, tbl[i].fire);
      chk($sformatf("rr_vec%0d", i), tbl[i].exp, tbl[i].exp != '0, 1'b0);
    end

    // wormhole hold across a 10-cycle stall, owner req dropped part of the time
    do_reset("reset_midpacket_rr");
    drive(5'b10100, HEAD, 1'b0);
    chk("wh_grant", 5'b00100, 1'b1, 1'b0);
    drive(5'b10100, HEAD, 1'b1);
    drive(5'b10100, BODY, 1'b1);
    chk("wh_body", 5'b00100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive((i < 5) ? 5'b10100 : 5'b10000, BODY, 1'b0);
      chk($sformatf("wh_stall%0d", i), 5'b00100, 1'b1, 1'b0);
    end
    drive(5'b10100, BODY, 1'b1);
    chk("wh_body2", 5'b00100, 1'b1, 1'b0);
    drive(5'b10100, TAIL, 1'b1);
    chk("wh_handover", 5'b10000, 1'b1, 1'b0);

    // single requester with back-to-back head_tail packets
    do_reset("reset_midpacket_wh");
    for (int i = 0; i < 2; i++) begin
      drive(5'b01000, HT, 1'b1);
      chk($sformatf("single_grant%0d", i), 5'b01000, 1'b1, 1'b0);
      drive(5'b01000, HT, 1'b1);
      chk($sformatf("single_idle%0d", i), 5'b00000, 1'b0, 1'b0);
    end

    // wrap-around from ptr=4
    do_reset("reset_before_wrap");
    drive(5'b10001, HEAD, 1'b0);
    chk("wrap_in0", 5'b00001, 1'b1, 1'b0);
    drive(5'b10001, TAIL, 1'b1);
    chk("wrap_in4", 5'b10000, 1'b1, 1'b0);

    // stalled owner: watchdog release or indefinite hold
    do_reset("reset_midpacket_wrap");
    drive(5'b00010, HEAD, 1'b0);
    chk("wd_lock", 5'b00010, 1'b1, 1'b0);
`ifdef OPA_WATCHDOG_EN
    for (int k = 1; k <= TB_TIMEOUT + 3; k++) begin
      drive(5'b00110, BODY, 1'b0);
      if (k < TB_TIMEOUT)       chk($sformatf("wd_stall%0d", k), 5'b00010, 1'b1, 1'b0);
      else if (k == TB_TIMEOUT) chk("wd_fire", 5'b00100, 1'b1, 1'b1);
      else                      chk($sformatf("wd_after%0d", k), 5'b00100, 1'b1, 1'b0);
    end
`else
    for (int k = 1; k <= 2 * TB_TIMEOUT; k++) begin
      drive(5'b00110, BODY, 1'b0);
      chk($sformatf("wd_hold%0d", k), 5'b00010, 1'b1, 1'b0);
    end
`endif

    // randomized traffic against the reference model
    do_reset("reset_midpacket_wd");
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0]   rq;
      logic [2*N-1:0] ft;
      logic           fr;
      rq = N'($urandom);
      ft = (2*N)'($urandom);
      fr = ($urandom_range(0, 3) != 0);
      drive_raw(rq, ft, fr);
      chk($sformatf("rand%0d", c), (m_owner < 0) ? '0 : (N'(1) << m_owner),
          m_owner >= 0, m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
